// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with standard/FWFT read, occupancy flags and sticky errors
// Flags and count are registered from count_next so no request input reaches an output combinationally.

module sync_fifo #(
  parameter int ADDRWIDTH     = 8,
  parameter int WIDTH         = 8,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (1 << ADDRWIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enqueue,
  input  logic                 dequeue,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDRWIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] DEPTH_C = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] AF_C    = (ADDRWIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDRWIDTH:0] AE_C    = (ADDRWIDTH+1)'(AEMPTY_THRESH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDRWIDTH:0]   wr_ptr;
  logic [ADDRWIDTH:0]   rd_ptr;
  logic [ADDRWIDTH:0]   count_q;
  logic [ADDRWIDTH:0]   count_next;
  logic [ADDRWIDTH-1:0] rd_addr;
  logic                 full_q;
  logic                 empty_q;
  logic                 afull_q;
  logic                 aempty_q;
  logic                 ovf_q;
  logic                 unf_q;
  logic                 deq_ok;
  logic                 enq_ok;

  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign deq_ok  = dequeue & ~empty_q;
  assign enq_ok  = enqueue & (~full_q | deq_ok);
  assign rd_addr = rd_ptr[ADDRWIDTH-1:0];

  always_comb begin
    count_next = count_q;
    case ({enq_ok, deq_ok})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (enq_ok) wr_ptr <= wr_ptr + 1'b1;
      if (deq_ok) rd_ptr <= rd_ptr + 1'b1;
      count_q  <= count_next;
      full_q   <= (count_next == DEPTH_C);
      empty_q  <= (count_next == '0);
      afull_q  <= (count_next >= AF_C);
      aempty_q <= (count_next <= AE_C);
      if (enqueue && !enq_ok) ovf_q <= 1'b1;
      if (dequeue && !deq_ok) unf_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (reset && !clear && enq_ok) mem[wr_ptr[ADDRWIDTH-1:0]] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty_q ? '0 : mem[rd_addr];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset)      dout_q <= '0;
      else if (clear)  dout_q <= '0;
      else if (deq_ok) dout_q <= mem[rd_addr];
    end
    assign data_out = dout_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo, standard and FWFT instances driven in lockstep
module tb_sync_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       enqueue = 1'b0;
  logic       dequeue = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] s_dout, f_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] s_count, f_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  always #5 clock = ~clock;

  sync_fifo #(.ADDRWIDTH(2), .WIDTH(8), .FWFT(0), .AFULL_THRESH(2), .AEMPTY_THRESH(1)) dut (
    .clock(clock), .reset(reset), .clear(clear), .enqueue(enqueue), .dequeue(dequeue),
    .data_in(data_in), .data_out(s_dout), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo #(.ADDRWIDTH(2), .WIDTH(8), .FWFT(1), .AFULL_THRESH(2), .AEMPTY_THRESH(1)) dut_f (
    .clock(clock), .reset(reset), .clear(clear), .enqueue(enqueue), .dequeue(dequeue),
    .data_in(data_in), .data_out(f_dout), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("std_data_out", {24'd0, s_dout}, {24'd0, exp_dout});
    chk("std_count", {29'd0, s_count}, n);
    chk("std_full", {31'd0, s_full}, {31'd0, n == 4});
    chk("std_empty", {31'd0, s_empty}, {31'd0, n == 0});
    chk("std_almost_full", {31'd0, s_af}, {31'd0, n >= 2});
    chk("std_almost_empty", {31'd0, s_ae}, {31'd0, n <= 1});
    chk("std_overflow", {31'd0, s_ovf}, {31'd0, exp_ovf});
    chk("std_underflow", {31'd0, s_unf}, {31'd0, exp_unf});
    chk("fwft_count", {29'd0, f_count}, n);
    chk("fwft_empty", {31'd0, f_empty}, {31'd0, n == 0});
    chk("fwft_full", {31'd0, f_full}, {31'd0, n == 4});
    chk("fwft_flags", {30'd0, f_ovf, f_unf}, {30'd0, exp_ovf, exp_unf});
    chk("fwft_almost", {30'd0, f_af, f_ae}, {30'd0, n >= 2, n <= 1});
    if (n > 0) chk("fwft_head", {24'd0, f_dout}, {24'd0, q[0]});
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = 8'h00;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  task automatic step(input logic e, input logic d, input logic [7:0] din, input logic c);
    bit dq, eq;
    enqueue = e;
    dequeue = d;
    data_in = din;
    clear   = c;
    @(posedge clock);
    if (c) begin
      model_reset();
    end else begin
      dq = d && (q.size() > 0);
      eq = e && (q.size() < 4 || dq);
      if (dq) exp_dout = q.pop_front();
      if (eq) q.push_back(din);
      if (e && !eq) exp_ovf = 1'b1;
      if (d && !dq) exp_unf = 1'b1;
    end
    #1;
    enqueue = 1'b0;
    dequeue = 1'b0;
    clear   = 1'b0;
    check_all();
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Fill to full, then drain in order
    for (int i = 0; i < 4; i++) step(1, 0, 8'hA1 + 8'(i), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0);

    // Write-through on a full FIFO
    for (int i = 0; i < 4; i++) step(1, 0, 8'hA1 + 8'(i), 0);
    step(1, 1, 8'hB0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0);

    // Sticky overflow and underflow, then clear (clear wins over requests)
    for (int i = 0; i < 4; i++) step(1, 0, 8'hC0 + 8'(i), 0);
    step(1, 0, 8'hCF, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(1, 0, 8'hD1, 0);
    step(1, 1, 8'hD2, 1);
    step(0, 0, 8'h00, 0);

    // FWFT head visibility
    step(1, 0, 8'h5C, 0);
    step(1, 0, 8'h5D, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);

    // Wrap-around: alternating pairs, then simultaneous pairs at count 3
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'h60 + 8'(i), 0);
      step(0, 1, 8'h00, 0);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 8'h70 + 8'(i), 0);
    for (int i = 0; i < 10; i++) step(1, 1, 8'h80 + 8'(i), 0);

    // Randomised traffic against the queue model
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 40) == 0));

    // Asynchronous reset mid-burst with three words held
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h90 + 8'(i), 0);
    step(0, 1, 8'h00, 0);
    step(1, 0, 8'h93, 0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    step(1, 0, 8'h11, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock parametrised FIFO. It is the same-clock-domain successor to the team's dual-clock FIFO and is used wherever producer and consumer share one clock. Compared with the dual-clock block it adds:
- selectable standard or first-word-fall-through (FWFT) read mode;
- an occupancy count and programmable almost-full / almost-empty thresholds;
- sticky overflow / underflow error flags;
- a synchronous flush;
- write-through when full (a write is accepted in the same cycle as a read).

Parameters:
ADDRWIDTH, 8, log2 of depth; DEPTH = 2**ADDRWIDTH entries
WIDTH, 8, data word width in bits
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH (range 1..DEPTH)
AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH (range 0..DEPTH-1)

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush, active-high
enqueue  input  1  write request
dequeue  input  1  read request / head acknowledge
data_in  input  WIDTH  write data
data_out  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDRWIDTH+1  occupancy, 0..DEPTH
overflow  output  1  sticky: an enqueue was rejected
underflow  output  1  sticky: a dequeue was rejected

Behaviour:
- Reset (reset low, asynchronous, mid-operation included):
  - pointers, count, data_out, overflow and underflow go to 0;
  - empty=1, almost_empty=1, full=0, almost_full=0;
  - memory contents are not cleared.
- Pointers are ADDRWIDTH+1 bits wide; the MSB is the wrap bit. Address = low ADDRWIDTH bits. Pointers wrap modulo 2*DEPTH.
- The flags and count all come from registered state. They change only after a clock edge, with no combinational path from enqueue/dequeue.
- Accept rules, evaluated on the state before the edge:
  - deq_ok = dequeue & !empty
  - enq_ok = enqueue & (!full | deq_ok). Write-through when full: a simultaneous read frees the slot.
  - Empty with both requests: only the write is accepted. No bypass; the count becomes 1.
- Count update: count_next = count + enq_ok - deq_ok. Both accepted means count is unchanged and both pointers advance.
- Error flags:
  - enqueue & !enq_ok sets overflow;
  - dequeue & !deq_ok sets underflow;
  - both flags hold until reset or clear;
  - rejected requests never move the pointers or the memory.
- Standard read (FWFT=0):
  - on deq_ok, data_out is loaded with memory[rd_addr] at that edge (1-cycle latency);
  - otherwise data_out holds its value.
- FWFT read (FWFT=1):
  - while !empty, data_out = memory[rd_addr] (the head word), driven from the registered pointer and an asynchronous memory read;
  - dequeue acknowledges the head, and the next word appears after the edge;
  - a word written into an empty FIFO is visible, with empty=0, one cycle after the write edge;
  - data_out is unspecified while empty.
- clear (synchronous):
  - priority over enqueue/dequeue in the same cycle; both are ignored and no error flag is set;
  - resets pointers, count, data_out, overflow and underflow to their reset values at the edge.
- Memory write occurs only on enq_ok, at memory[wr_addr].

Test Plan:
1. ADDRWIDTH=2, FWFT=0: enqueue 0xA1..0xA4 → full=1, count=4, almost_full=1 (AFULL_THRESH=2). Then dequeue four times → data_out 0xA1,0xA2,0xA3,0xA4, each one cycle after its dequeue edge; empty=1, count=0.
2. Full FIFO holding 0xA1..0xA4, enqueue 0xB0 and dequeue in the same cycle → data_out=0xA1, count stays 4, overflow=0. Draining then yields 0xA2,0xA3,0xA4,0xB0.
3. Full FIFO, enqueue alone → overflow=1 and count=4. Empty FIFO, dequeue alone → underflow=1 and data_out unchanged. Both flags persist until clear; after clear both are 0 and count=0.
4. FWFT=1, empty FIFO, enqueue 0x5C → on the next cycle empty=0 and data_out=0x5C with no dequeue. Enqueue 0x5D, then dequeue → data_out=0x5D after the edge.
5. Wrap-around: 10 interleaved write/read pairs on a depth-4 FIFO → data order is preserved, count never exceeds 4, and full/empty are correct across the pointer MSB toggle.
6. Pull reset low mid-burst with count=3 and asynchronously to clock → outputs take reset values immediately. After release, enqueue 0x11 then dequeue returns 0x11, with no stale data.
